// File: rtl/uart_rx_fifo.sv
// Receive-side circular byte buffer between the UART receiver and the host.
// Registered read port with a one-cycle rd_valid pulse, plus a sticky overrun flag.
module uart_rx_fifo #(
  parameter int DBITS      = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DBITS-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic                  clear_overrun,
  output logic [DBITS-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

  logic [DBITS-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  wr_drop;

  // A full buffer still takes a write when a read frees a slot in the same cycle.
  assign rd_accept = rd_en & ~empty;
  assign wr_accept = wr_valid & (~full | rd_accept);
  assign wr_drop   = wr_valid & ~wr_accept;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full, read and write share a slot; the read sees the old byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept)
        rd_data <= mem[rd_ptr];
    end
  end

  // A drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (wr_drop)
      overrun <= 1'b1;
    else if (clear_overrun)
      overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single-cycle vectors plus
// hand-written fill/wrap, overrun, simultaneous-access and async reset sequences.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       clear_overrun;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DBITS(8), .ADDR_WIDTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .clear_overrun (clear_overrun),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       re;
    logic       co;
    logic       erv;
    logic [7:0] erd;
    logic [4:0] ecnt;
    logic       eemp;
    logic       efull;
    logic       eov;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic erv, input logic [7:0] erd,
                           input logic [4:0] ecnt, input logic eemp, input logic efull,
                           input logic eov);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(erv));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(erd));
    chk({tag, ".count"},    32'(count),    32'(ecnt));
    chk({tag, ".empty"},    32'(empty),    32'(eemp));
    chk({tag, ".full"},     32'(full),     32'(efull));
    chk({tag, ".overrun"},  32'(overrun),  32'(eov));
  endtask

  // Drive for one cycle, then leave us 1 time unit past the edge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic re, input logic co);
    wr_valid      = wv;
    wr_data       = wd;
    rd_en         = re;
    clear_overrun = co;
    @(posedge clk);
    #1;
    wr_valid      = 1'b0;
    rd_en         = 1'b0;
    clear_overrun = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, base + 8'(i), 1'b0, 1'b0);
      chk("fill.count", 32'(count), 32'(i + 1));
    end
    chk("fill.full", 32'(full), 32'd1);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".rd_data"},  32'(rd_data),  32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               wv    wd     re    co    erv   erd    cnt  emp   full  ov
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h33, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h33, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44, 5'd0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    rd_en = 1'b0;
    clear_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset", 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);

    for (int v = 0; v < 15; v++) begin
      step(vecs[v].wv, vecs[v].wd, vecs[v].re, vecs[v].co);
      check_all($sformatf("vec%0d", v), vecs[v].erv, vecs[v].erd, vecs[v].ecnt,
                vecs[v].eemp, vecs[v].efull, vecs[v].eov);
    end

    // Fill and wrap
    fill(8'h00);
    chk("wrap.count16", 32'(count), 32'd16);
    for (int i = 0; i < 8; i++)
      read_expect("wrap.rd_first", 8'(i));
    chk("wrap.count8", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++)
      step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    check_all("wrap.refull", 1'b0, 8'h07, 5'd16, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      read_expect("wrap.rd_all", 8'h08 + 8'(i));
    check_all("wrap.end", 1'b1, 8'h17, 5'd0, 1'b1, 1'b0, 1'b0);

    // Overrun
    fill(8'h00);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check_all("ovr.drop", 1'b0, 8'h17, 5'd16, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++)
      read_expect("ovr.rd", 8'(i));
    check_all("ovr.drained", 1'b1, 8'h0F, 5'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr.cleared", 32'(overrun), 32'd0);
    fill(8'h00);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    check_all("ovr.set_wins", 1'b0, 8'h0F, 5'd16, 1'b0, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr.cleared2", 32'(overrun), 32'd0);

    // Simultaneous read+write while full
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check_all("full_rw", 1'b1, 8'h00, 5'd16, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++)
      read_expect("full_rw.rd", 8'(i));
    read_expect("full_rw.last", 8'h55);
    check_all("full_rw.end", 1'b1, 8'h55, 5'd0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    read_expect("arst.pre_rd", 8'hC0);
    chk("arst.pre_count", 32'(count), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check_all("arst.async", 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    chk("arst.wr_count", 32'(count), 32'd1);
    read_expect("arst.rd", 8'h42);
    chk("arst.end_count", 32'(count), 32'd0);
    chk("arst.end_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
